boot_sequencer: RTL and testbench
=================================

// Module: boot_sequencer
// PURPOSE
//  Top-level sequencer for the bootstrap SRAM load path. On start_i it grants the SRAM to the
//  internal write path (micro_control_o=0), then drives control_mem's write_enable, one fixed-length
//  slot per 32-bit FIFO word, until boot_len words are written. It then hands the SRAM to the
//  microprocessor (micro_control_o=1). It also gates the FIFO pop so that each word is popped exactly once.
// PARAMETERS
//  LEN_WIDTH      16  width of the boot length and the word counter
//  SLOT_CYCLES    14  cycles per 32-bit word write slot (control_mem counter states 0..13)
//  TIMEOUT_CYCLES 256 max consecutive cycles waiting on a non-empty FIFO before error
//  TO_WIDTH       9   width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TO_WIDTH
// PORTS
//  boot_seq_clk_i      in   1          single clock, posedge (control_mem samples on negedge)
//  boot_seq_rst_n_i    in   1          asynchronous active-low reset
//  start_i             in   1          1-cycle start pulse; ignored while busy_o=1
//  boot_len_i          in   LEN_WIDTH  number of 32-bit words to load, sampled on accepted start
//  fifo_empty_i        in   1          boot FIFO empty flag
//  read_fifo_i         in   1          pop request from control_mem
//  fifo_rd_o           out  1          gated pop to the FIFO
//  write_enable_o      out  2          to control_mem: [1]=run counter, [0]=write mode
//  micro_control_o     out  1          0=sequencer owns SRAM, 1=microprocessor owns SRAM
//  busy_o              out  1          load in progress
//  done_o              out  1          sticky: load completed
//  error_o             out  1          sticky: FIFO starvation timeout
//  words_written_o     out  LEN_WIDTH  completed word slots
// BEHAVIOUR
//  Reset values (async, on rst_n=0): state=IDLE, write_enable_o=2'b00, micro_control_o=0, busy_o=0,
//   done_o=0, error_o=0, words_written_o=0, slot/timeout counters=0. fifo_rd_o=0 (combinational from state).
//  FSM states: IDLE, WAIT_DATA, WRITE, GAP, DONE, ERROR. All outputs are registered except fifo_rd_o.
//  IDLE/DONE/ERROR + start_i: latch boot_len_i, clear done/error/words.
//   - boot_len_i=0: go to DONE directly (done_o=1 the next cycle, no FIFO pop).
//   - Otherwise: go to WAIT_DATA with micro_control_o=0 and busy_o=1.
//  WAIT_DATA: write_enable_o=00.
//   - !fifo_empty_i: go to WRITE and clear the timeout counter.
//   - fifo_empty_i: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 while still
//     empty: go to ERROR.
//  WRITE: write_enable_o=2'b11. The slot counter counts 0..SLOT_CYCLES-1. At SLOT_CYCLES-1:
//   words_written+1, then go to GAP.
//  GAP: exactly 1 cycle, write_enable_o=00 so that control_mem's counter returns to 0.
//   - words_written==len: go to DONE.
//   - Otherwise: go to WAIT_DATA.
//   Each word therefore costs SLOT_CYCLES+1 cycles when the FIFO is never empty (WAIT_DATA also
//   takes 1 cycle: 16 cycles per word at the defaults).
//  fifo_rd_o = read_fifo_i & (state==WRITE) & (slot_cnt==0). This suppresses the spurious pop that
//   control_mem raises in counter state 0 during GAP/WAIT_DATA/IDLE.
//  DONE: micro_control_o=1, busy_o=0, done_o=1, write_enable_o=00.
//  ERROR: micro_control_o=1, busy_o=0, error_o=1. words_written_o holds the last count.
//  start_i while busy_o=1 is ignored. fifo_empty_i is not checked inside WRITE; the word is already latched.
//  Counters never wrap: the slot counter is clamped to SLOT_CYCLES-1. words_written stops at len.
//  Reset mid-slot: all outputs return to reset values immediately. A partial SRAM word is
//   discarded and a new start reloads from address 0; the SRAM address is reset by control_mem's own reset.
// STRUCTURE
//  boot_pkg: state localparams (3-bit), WE_IDLE=2'b00, WE_WRITE=2'b11, default SLOT_CYCLES.
//  One sub-module: boot_timeout_counter (clear/enable/expire flag, TO_WIDTH bits). The rest is flat.
// TESTING
//  1 Assert reset, then release -> all outputs 0, write_enable_o=00, fifo_rd_o=0 even if read_fifo_i=1.
//  2 boot_len=3, FIFO never empty, read_fifo_i driven by a control_mem model -> exactly 3 fifo_rd_o
//    pulses 16 cycles apart; done_o=1 and micro_control_o=1 48 cycles after start.
//  3 boot_len=0 + start -> done_o=1 the next cycle, zero fifo_rd_o, write_enable_o stays 00.
//  4 boot_len=2, FIFO empty after word 1, TIMEOUT_CYCLES=8 -> error_o=1 after 8 WAIT cycles,
//    words_written_o=1, micro_control_o=1.
//  5 Reset asserted at slot cycle 7 of word 2 -> write_enable_o=00 and busy_o=0 asynchronously;
//    a new start restarts with words_written_o=0.
//  6 start_i pulsed again while busy (len=5 then len=1) -> ignored; 5 words are written.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the bootstrap SRAM load sequencer.
package boot_pkg;

    // Sequencer states, 3-bit encoded.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_WRITE     = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    // control_mem write_enable encodings: [1]=run counter, [0]=write mode.
    localparam logic [1:0] WE_IDLE  = 2'b00;
    localparam logic [1:0] WE_WRITE = 2'b11;

    // Default geometry of one 32-bit word write slot and the starvation limit.
    localparam int SLOT_CYCLES_DEFAULT    = 14;
    localparam int TIMEOUT_CYCLES_DEFAULT = 256;
    localparam int TO_WIDTH_DEFAULT       = 9;

    // States in which a new start request is accepted.
    function automatic logic accepts_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

    // States that make up an in-progress load.
    function automatic logic is_loading(input state_t s);
        return (s == ST_WAIT_DATA) || (s == ST_WRITE) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/boot_timeout_counter.sv
// Saturating starvation counter: counts enabled cycles and flags the last allowed one.
module boot_timeout_counter
    import boot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TO_WIDTH       = TO_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] count;

    // Count consecutive enabled cycles, holding at the last value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + TO_WIDTH'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/boot_sequencer.sv
// Bootstrap SRAM load sequencer: writes boot_len FIFO words through control_mem, one
// fixed-length slot per word, then hands the SRAM over to the microprocessor.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int LEN_WIDTH      = 16,
    parameter int SLOT_CYCLES    = SLOT_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TO_WIDTH       = TO_WIDTH_DEFAULT
) (
    input  logic                 boot_seq_clk_i,
    input  logic                 boot_seq_rst_n_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] boot_len_i,
    input  logic                 fifo_empty_i,
    input  logic                 read_fifo_i,
    output logic                 fifo_rd_o,
    output logic [1:0]           write_enable_o,
    output logic                 micro_control_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LEN_WIDTH-1:0] words_written_o
);

    localparam int                  SLOT_WIDTH = $clog2(SLOT_CYCLES + 1);
    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(SLOT_CYCLES - 1);

    state_t                state;
    state_t                next_state;
    logic [SLOT_WIDTH-1:0] slot_cnt;
    logic [LEN_WIDTH-1:0]  len;
    logic                  start_ok;
    logic                  slot_end;
    logic                  to_clear;
    logic                  to_enable;
    logic                  to_expired;

    logic [1:0]            we_d;
    logic                  micro_control_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  error_d;

    assign start_ok = start_i && accepts_start(state);
    assign slot_end = (state == ST_WRITE) && (slot_cnt == SLOT_LAST);

    // Starvation timer runs only across consecutive empty cycles in WAIT_DATA.
    assign to_enable = (state == ST_WAIT_DATA) && fifo_empty_i;
    assign to_clear  = !to_enable;

    boot_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_timeout (
        .clk     (boot_seq_clk_i),
        .rst_n   (boot_seq_rst_n_i),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    // State register.
    always_ff @(posedge boot_seq_clk_i or negedge boot_seq_rst_n_i) begin
        if (!boot_seq_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    next_state = (boot_len_i == '0) ? ST_DONE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!fifo_empty_i) begin
                    next_state = ST_WRITE;
                end else if (to_expired) begin
                    next_state = ST_ERROR;
                end
            end
            ST_WRITE: begin
                if (slot_cnt == SLOT_LAST) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                next_state = (words_written_o == len) ? ST_DONE : ST_WAIT_DATA;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode: next-cycle values of the registered outputs, taken from the state being entered.
    always_comb begin
        we_d            = (next_state == ST_WRITE) ? WE_WRITE : WE_IDLE;
        busy_d          = is_loading(next_state);
        micro_control_d = (next_state == ST_DONE) || (next_state == ST_ERROR);
        done_d          = (next_state == ST_DONE);
        error_d         = (next_state == ST_ERROR);
    end

    // Registered outputs, so they change in the same edge as the state they describe.
    always_ff @(posedge boot_seq_clk_i or negedge boot_seq_rst_n_i) begin
        if (!boot_seq_rst_n_i) begin
            write_enable_o  <= WE_IDLE;
            micro_control_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            write_enable_o  <= we_d;
            micro_control_o <= micro_control_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            error_o         <= error_d;
        end
    end

    // Slot counter: 0..SLOT_CYCLES-1 within WRITE, clamped at the last slot cycle, 0 elsewhere.
    always_ff @(posedge boot_seq_clk_i or negedge boot_seq_rst_n_i) begin
        if (!boot_seq_rst_n_i) begin
            slot_cnt <= '0;
        end else if (state != ST_WRITE) begin
            slot_cnt <= '0;
        end else if (slot_cnt != SLOT_LAST) begin
            slot_cnt <= slot_cnt + SLOT_WIDTH'(1);
        end
    end

    // Load length latch and completed-word count; the count never passes the latched length.
    always_ff @(posedge boot_seq_clk_i or negedge boot_seq_rst_n_i) begin
        if (!boot_seq_rst_n_i) begin
            len             <= '0;
            words_written_o <= '0;
        end else if (start_ok) begin
            len             <= boot_len_i;
            words_written_o <= '0;
        end else if (slot_end && (words_written_o != len)) begin
            words_written_o <= words_written_o + LEN_WIDTH'(1);
        end
    end

    // Only the first cycle of a write slot may pop; control_mem also raises its request
    // in counter state 0 while idle, waiting or in the gap, and those must not pop.
    assign fifo_rd_o = read_fifo_i && (state == ST_WRITE) && (slot_cnt == '0);

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: randomized loads against a cycle-arithmetic
// reference model, with expected pops and completions checked by a scoreboard monitor.
module tb_boot_sequencer;

    localparam int LEN_WIDTH = 16;
    localparam int SLOT      = 14;
    localparam int TMO       = 8;
    localparam int NEVER     = 100000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LEN_WIDTH-1:0] boot_len = '0;
    logic                 fifo_empty = 1'b1;
    logic                 read_fifo;
    logic                 fifo_rd;
    logic [1:0]           we;
    logic                 mc;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [LEN_WIDTH-1:0] words;

    always #5 clk = ~clk;

    boot_sequencer #(
        .LEN_WIDTH      (LEN_WIDTH),
        .SLOT_CYCLES    (SLOT),
        .TIMEOUT_CYCLES (TMO),
        .TO_WIDTH       (4)
    ) dut (
        .boot_seq_clk_i   (clk),
        .boot_seq_rst_n_i (rst_n),
        .start_i          (start),
        .boot_len_i       (boot_len),
        .fifo_empty_i     (fifo_empty),
        .read_fifo_i      (read_fifo),
        .fifo_rd_o        (fifo_rd),
        .write_enable_o   (we),
        .micro_control_o  (mc),
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (error),
        .words_written_o  (words)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // control_mem model: counter runs on negedge while write_enable[1] is set,
    // returns to 0 otherwise, and requests a pop whenever it sits in state 0.
    int cm_cnt;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)       cm_cnt <= 0;
        else if (we[1])   cm_cnt <= (cm_cnt == SLOT - 1) ? SLOT - 1 : cm_cnt + 1;
        else              cm_cnt <= 0;
    end
    assign read_fifo = (cm_cnt == 0);

    // FIFO model: after a load is kicked off, or after each pop, the FIFO stays empty
    // for the next scheduled number of cycles and is non-empty from then on.
    int delay_q[$];
    int nonempty_at = 0;
    int kick_cnt = 0;
    int kick_seen = 0;
    always @(posedge clk) begin
        #1;
        if (kick_cnt != kick_seen) begin
            kick_seen = kick_cnt;
            if (delay_q.size() > 0) nonempty_at = cyc + delay_q.pop_front();
            else                    nonempty_at = cyc + NEVER;
        end else if (fifo_rd) begin
            if (delay_q.size() > 0) nonempty_at = cyc + 1 + delay_q.pop_front();
            else                    nonempty_at = cyc + 1 + NEVER;
        end
        fifo_empty = (cyc < nonempty_at);
    end

    // Scoreboard.
    typedef enum int {EV_POP = 0, EV_DONE = 1, EV_ERROR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       words;
        int       busy_cycles;
        int       we_cycles;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input ev_kind_t k, input int c, input int w, input int b, input int wc);
        ev_t e;
        e.kind = k; e.cyc = c; e.words = w; e.busy_cycles = b; e.we_cycles = wc;
        exp_q.push_back(e);
    endtask

    // Reference model. Start accepted at edge s; WAIT_DATA occupies cycle s onward.
    // A word costs (empty wait) + 1 WAIT cycle + SLOT write cycles + 1 gap cycle;
    // more than TMO-1 empty wait cycles ends the load in ERROR after TMO cycles.
    int dly[8];
    task automatic predict(input int s, input int len, input int cut, output int end_cyc);
        int w0;
        int wait_n;
        int p;
        w0 = s;
        end_cyc = s;
        if (len == 0) begin
            push_ev(EV_DONE, s, 0, 0, 0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (i == 0) wait_n = dly[0];
            else        wait_n = (dly[i] > SLOT) ? dly[i] - SLOT : 0;
            if (wait_n >= TMO) begin
                end_cyc = w0 + TMO;
                if (end_cyc < cut) push_ev(EV_ERROR, end_cyc, i, end_cyc - s, SLOT * i);
                return;
            end
            p = w0 + wait_n + 1;
            if (p < cut) push_ev(EV_POP, p, 0, 0, 0);
            w0 = p + SLOT + 1;
        end
        end_cyc = w0;
        if (end_cyc < cut) push_ev(EV_DONE, end_cyc, len, end_cyc - s, SLOT * len);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pops the FIFO or finishes a load.
    int  run_id = 0;
    int  mon_run = 0;
    bit  armed = 1'b0;
    int  busy_n = 0;
    int  we_n = 0;
    int  bad_we_n = 0;
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (run_id != mon_run) begin
            mon_run = run_id; armed = 1'b1; busy_n = 0; we_n = 0; bad_we_n = 0;
        end
        if (fifo_rd) begin
            check("pop_scheduled", int'(exp_q.size() > 0 && exp_q[0].kind == EV_POP), 1);
            if (exp_q.size() > 0 && exp_q[0].kind == EV_POP) begin
                e = exp_q.pop_front();
                check("pop_cycle", cyc, e.cyc);
            end
        end
        if (armed && (done || error)) begin
            armed = 1'b0;
            check("end_scheduled", int'(exp_q.size() > 0 && exp_q[0].kind != EV_POP), 1);
            if (exp_q.size() > 0 && exp_q[0].kind != EV_POP) begin
                e = exp_q.pop_front();
                check("end_kind", (done ? 1 : 0) + (error ? 2 : 0), int'(e.kind));
                check("end_cycle", cyc, e.cyc);
                check("end_words", int'(words), e.words);
                check("end_micro_control", int'(mc), 1);
                check("end_busy", int'(busy), 0);
                check("end_write_enable", int'(we), 0);
                check("busy_cycles", busy_n, e.busy_cycles);
                check("write_cycles", we_n, e.we_cycles);
                check("illegal_we_cycles", bad_we_n, 0);
            end
        end else if (armed) begin
            if (busy) busy_n++;
            if (we == 2'b11) we_n++;
            else if (we != 2'b00) bad_we_n++;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("event_missed_at_cycle", cyc, e.cyc);
        end
    end

    // Issue one load. cut_after > 0 aborts expectations at s+cut_after (caller resets there).
    task automatic do_run(input int len, input int extra_at, input int cut_after, output int s);
        int end_cyc;
        int cut;
        @(posedge clk); #2;
        s = cyc + 1;
        cut = (cut_after > 0) ? s + cut_after : NEVER * 10;
        delay_q.delete();
        for (int i = 0; i < len; i++) delay_q.push_back(dly[i]);
        predict(s, len, cut, end_cyc);
        start = 1'b1;
        boot_len = LEN_WIDTH'(len);
        run_id++;
        if (len > 0) kick_cnt++;
        @(posedge clk); #2;
        start = 1'b0;
        boot_len = LEN_WIDTH'($urandom);
        if (cut_after > 0) return;
        for (int n = 0; n < 2000 && cyc < end_cyc + 2; n++) begin
            @(posedge clk); #2;
            if (extra_at > 0 && cyc + 1 == s + extra_at) begin
                start = 1'b1;
                boot_len = LEN_WIDTH'(1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_write_enable"}, int'(we), 0);
        check({tag, "_micro_control"}, int'(mc), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_words"}, int'(words), 0);
        check({tag, "_fifo_rd"}, int'(fifo_rd), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;

        // Reset state, with control_mem requesting a pop in counter state 0.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_idle_outputs("after_reset");

        // Three words, FIFO never empty: pops 16 cycles apart, done 48 cycles after start.
        dly[0] = 0; dly[1] = 0; dly[2] = 0;
        do_run(3, 0, 0, s);

        // Zero-length load: done the next cycle, no pop, no write.
        do_run(0, 0, 0, s);

        // Starvation after word 1: exactly TMO empty WAIT cycles -> ERROR.
        dly[0] = 0; dly[1] = SLOT + TMO;
        do_run(2, 0, 0, s);

        // One empty cycle short of the timeout: load completes.
        dly[0] = 0; dly[1] = SLOT + TMO - 1;
        do_run(2, 0, 0, s);

        // Reset at slot cycle 7 of word 2.
        dly[0] = 0; dly[1] = 0; dly[2] = 0;
        do_run(3, 0, SLOT + 10, s);
        for (int n = 0; n < 100 && cyc < s + SLOT + 10; n++) begin
            @(posedge clk); #2;
        end
        check("we_before_reset", int'(we), 3);
        check("busy_before_reset", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_we", int'(we), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_words", int'(words), 0);
        delay_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_idle_outputs("post_abort");
        dly[0] = 1; dly[1] = 3;
        do_run(2, 0, 0, s);

        // Second start while busy is ignored: all 5 words still written.
        for (int i = 0; i < 5; i++) dly[i] = i;
        do_run(5, 20, 0, s);

        // Randomized loads, including starvation near the timeout boundary.
        for (int k = 0; k < 24; k++) begin
            int len;
            len = $urandom_range(0, 6);
            dly[0] = $urandom_range(0, TMO + 1);
            for (int i = 1; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) dly[i] = $urandom_range(SLOT + TMO - 2, SLOT + TMO + 4);
                else                           dly[i] = $urandom_range(0, SLOT + 4);
            end
            do_run(len, (len > 1) ? $urandom_range(2, 20) : 0, 0, s);
        end

        repeat (4) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
